fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch stage sitting directly downstream of the program counter. It takes the PC's current address, reads the synchronous instruction ROM, and holds the fetched instruction in an instruction register for decode. Once decode accepts the instruction, it pulses `next_ins` back to the program counter. It also tracks run/halt status against the PC's `done` flag and counts retired fetches.

## Interface
Parameters:
- `ADDR_W`, 9, PC / ROM address width.
- `INSTR_W`, 9, instruction width.
- `CNT_W`, 16, width of the retired-instruction counter.

Ports:
- `clock`  in  1  sole clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high; forces every register to its reset value.
- `start`  in  1  same signal that drives the PC's `start`; begins or restarts a program.
- `pc_in`  in  ADDR_W  PC's `pc_out`.
- `done`  in  1  PC's `done` flag.
- `rom_en`  out  1  ROM read enable.
- `rom_addr`  out  ADDR_W  ROM read address.
- `rom_data`  in  INSTR_W  ROM read data, valid the cycle after `rom_en`.
- `instr`  out  INSTR_W  instruction register.
- `instr_pc`  out  ADDR_W  address `instr` was fetched from.
- `instr_valid`  out  1  `instr` holds an unconsumed instruction.
- `instr_ready`  in  1  decode accepts `instr` this cycle.
- `next_ins`  out  1  to the PC's `nextIns`; advance request.
- `busy`  out  1  program running (not IDLE, not HALT).
- `halted`  out  1  program finished.
- `retired`  out  CNT_W  count of accepted instructions.

## Operation
States: IDLE, ISSUE, WAIT, VALID, HALT.
- **IDLE**
  - `start` → ISSUE.
- **ISSUE**
  - `rom_en`=1 and `rom_addr`=`pc_in`, both combinational.
  - → WAIT.
- **WAIT**
  - On the edge, `instr`←`rom_data` and `instr_pc`←the address latched in ISSUE.
  - → VALID.
- **VALID**
  - `instr_valid`=1.
  - If `instr_ready`=1: `next_ins`=1 combinationally, `retired` increments, and the state → ISSUE. The PC samples `nextIns` on the same edge, so `pc_in` already holds the new address in ISSUE.
  - If `instr_ready`=0: hold. `instr` and `instr_pc` stay stable and `next_ins`=0.
- **HALT**
  - `halted`=1, `instr_valid`=0, `next_ins`=0.
  - Exits only on `start` (→ ISSUE) or `reset`.

Priority, evaluated every cycle:
1. `start` → ISSUE. Drops `instr_valid`, clears `halted` and `retired`, forces `next_ins`=0.
2. `done`=1 while in ISSUE, WAIT or VALID → HALT. Any pending instruction is discarded and is not counted. `next_ins`=0 in that cycle even if `instr_ready`=1.
3. Normal transitions as listed above.

Other rules:
- `retired` saturates at all-ones.
- `next_ins` is never asserted outside VALID.
- `busy` = state ∈ {ISSUE, WAIT, VALID}.

## Timing
- Reset values:
  - state=IDLE.
  - `instr`=0, `instr_pc`=0, `retired`=0.
  - `instr_valid`=0, `next_ins`=0, `rom_en`=0, `busy`=0, `halted`=0.
- `rom_en`, `rom_addr`, `next_ins`, `instr_valid`, `busy` and `halted` decode from state plus inputs, with no extra register stage.
- Fetch latency: `start` edge → `instr_valid` high takes 3 cycles (ISSUE, WAIT, VALID).
- Peak throughput: one instruction per 3 cycles with `instr_ready` tied high.
- `done` is registered in the PC, so it rises one cycle after `pc_in` equals doneAddress. The instruction at doneAddress is fetched but discarded, and HALT is normally entered from WAIT.
- `start` mid-fetch aborts cleanly: the in-flight ROM data is ignored and the new fetch issues the cycle after `start`.
- `reset` mid-operation returns to IDLE immediately, asynchronously.

## Structure
- Shared package `cpu_pkg`:
  - `ADDR_W` and `INSTR_W` constants, reused by programcounter and decode.
  - `fetch_state_t` enum {IDLE, ISSUE, WAIT, VALID, HALT}.
- No sub-module. The ROM lives outside this block.
- The saturating counter is inline logic.

## Test plan
- **Basic fetch:** ROM[5]=9'h1A3, PC start address 5, `instr_ready`=1, pulse `start` → `rom_en` with `rom_addr`=5 one cycle later; `instr`=9'h1A3, `instr_pc`=5, `instr_valid`=1 three cycles after `start`; `next_ins` pulses once; `retired`=1.
- **Backpressure:** hold `instr_ready`=0 for 4 cycles in VALID → `instr` stable, `next_ins`=0 throughout; raise `instr_ready` → exactly one `next_ins` pulse, next `rom_addr`=6.
- **Halt:** doneAddress=8, start at 6, `instr_ready`=1 → instructions 6 and 7 accepted, `retired`=2, HALT entered, `halted`=1, `next_ins` stays 0.
- **Restart mid-fetch:** assert `start` while in WAIT → `instr_valid` stays 0, `retired`=0, and the fetch restarts from the new starting address.
- **Async reset:** assert `reset` between clock edges while in VALID → all outputs reach their reset values immediately, without waiting for a clock edge.
- **Saturation:** with `CNT_W`=4, run 20 accepts → `retired` holds at 15.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath widths and the fetch stage state type.
package cpu_pkg;

    localparam int ADDR_W  = 9;
    localparam int INSTR_W = 9;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        VALID,
        HALT
    } fetch_state_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch stage bus: PC side, ROM port, decode handshake and status.
// slave is the fetch unit's view; master is the environment's view.
interface fetch_unit_if #(
    parameter int ADDR_W  = cpu_pkg::ADDR_W,
    parameter int INSTR_W = cpu_pkg::INSTR_W,
    parameter int CNT_W   = 16
);
    logic               start;
    logic [ADDR_W-1:0]  pc_in;
    logic               done;
    logic               rom_en;
    logic [ADDR_W-1:0]  rom_addr;
    logic [INSTR_W-1:0] rom_data;
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  instr_pc;
    logic               instr_valid;
    logic               instr_ready;
    logic               next_ins;
    logic               busy;
    logic               halted;
    logic [CNT_W-1:0]   retired;

    modport slave (
        input  start, pc_in, done, rom_data, instr_ready,
        output rom_en, rom_addr, instr, instr_pc, instr_valid,
               next_ins, busy, halted, retired
    );

    modport master (
        output start, pc_in, done, rom_data, instr_ready,
        input  rom_en, rom_addr, instr, instr_pc, instr_valid,
               next_ins, busy, halted, retired
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: reads the ROM at the PC address, holds the result
// for decode, pulses next_ins on acceptance and tracks run/halt status.
//
// state | meaning
// IDLE  | waiting for the first start
// ISSUE | ROM read at pc_in, address captured
// WAIT  | ROM data arrives, loaded into the instruction register
// VALID | instruction offered to decode
// HALT  | program finished, waiting for start
module fetch_unit #(
    parameter int ADDR_W  = cpu_pkg::ADDR_W,
    parameter int INSTR_W = cpu_pkg::INSTR_W,
    parameter int CNT_W   = 16
) (
    input  logic         clock,
    input  logic         reset,
    fetch_unit_if.slave  bus
);
    import cpu_pkg::*;

    fetch_state_t       state_q, state_d;
    logic [ADDR_W-1:0]  addr_q;
    logic [ADDR_W-1:0]  instr_pc_q;
    logic [INSTR_W-1:0] instr_q;
    logic [CNT_W-1:0]   retired_q;
    logic               in_flight;
    logic               accept;
    logic               load;

    assign in_flight = (state_q == ISSUE) || (state_q == WAIT) || (state_q == VALID);

    // Next-state decode: start beats done, done beats normal sequencing.
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        if (bus.start) begin
            state_d = ISSUE;
        end else if (bus.done && in_flight) begin
            state_d = HALT;
        end else begin
            case (state_q)
                IDLE:  state_d = IDLE;
                ISSUE: state_d = WAIT;
                WAIT:  state_d = VALID;
                VALID: begin
                    if (bus.instr_ready) begin
                        accept  = 1'b1;
                        state_d = ISSUE;
                    end
                end
                HALT:    state_d = HALT;
                default: state_d = IDLE;
            endcase
        end
    end

    // ROM data is only kept when the fetch survives into VALID; an aborted
    // or halted fetch leaves the previous instruction untouched.
    assign load = (state_q == WAIT) && (state_d == VALID);

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Capture the issued address and load the instruction register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            addr_q     <= '0;
            instr_q    <= '0;
            instr_pc_q <= '0;
        end else begin
            if (state_q == ISSUE) addr_q <= bus.pc_in;
            if (load) begin
                instr_q    <= bus.rom_data;
                instr_pc_q <= addr_q;
            end
        end
    end

    // Retired counter: cleared by start, saturating at all-ones.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            retired_q <= '0;
        end else if (bus.start) begin
            retired_q <= '0;
        end else if (accept && (retired_q != '1)) begin
            retired_q <= retired_q + CNT_W'(1);
        end
    end

    assign bus.rom_en      = (state_q == ISSUE);
    assign bus.rom_addr    = bus.pc_in;
    assign bus.instr       = instr_q;
    assign bus.instr_pc    = instr_pc_q;
    assign bus.instr_valid = (state_q == VALID);
    assign bus.next_ins    = accept;
    assign bus.busy        = in_flight;
    assign bus.halted      = (state_q == HALT);
    assign bus.retired     = retired_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: behavioural PC and ROM around two DUTs (16-bit and
// 4-bit retired counters), directed scenarios followed by randomized programs.
module tb_fetch_unit;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       instr_ready = 1'b0;
    logic [8:0] start_addr = 9'd0;
    logic [8:0] done_addr = 9'h1FF;
    logic [8:0] pc;
    logic       done;
    logic [8:0] rom_data;
    logic [8:0] rom [512];
    logic [8:0] exp_addr;
    logic [8:0] held;

    int total = 0;
    int bad = 0;
    int pulses;
    int got;
    int cyc;
    int n;
    int sa;

    always #5 clock = ~clock;

    fetch_unit_if #(.ADDR_W(9), .INSTR_W(9), .CNT_W(16)) if1 ();
    fetch_unit_if #(.ADDR_W(9), .INSTR_W(9), .CNT_W(4))  if2 ();

    assign if1.start = start;
    assign if1.pc_in = pc;
    assign if1.done = done;
    assign if1.rom_data = rom_data;
    assign if1.instr_ready = instr_ready;
    assign if2.start = start;
    assign if2.pc_in = pc;
    assign if2.done = done;
    assign if2.rom_data = rom_data;
    assign if2.instr_ready = instr_ready;

    fetch_unit #(.ADDR_W(9), .INSTR_W(9), .CNT_W(16)) u_dut (
        .clock (clock),
        .reset (reset),
        .bus   (if1)
    );

    fetch_unit #(.ADDR_W(9), .INSTR_W(9), .CNT_W(4)) u_dut_sat (
        .clock (clock),
        .reset (reset),
        .bus   (if2)
    );

    // Program counter: loads on start, advances on next_ins, done is a
    // registered compare against doneAddress.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pc   <= 9'd0;
            done <= 1'b0;
        end else if (start) begin
            pc   <= start_addr;
            done <= 1'b0;
        end else begin
            if (if1.next_ins) pc <= pc + 9'd1;
            done <= (pc == done_addr);
        end
    end

    // Synchronous ROM.
    always_ff @(posedge clock) begin
        if (if1.rom_en) rom_data <= rom[if1.rom_addr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clock);
    endtask

    initial begin
        for (int i = 0; i < 512; i++) rom[i] = 9'($urandom);
        rom[5]  = 9'h1A3;
        rom[31] = 9'h155;

        // Reset values
        #1;
        chk("rst_instr", if1.instr, 0);
        chk("rst_instr_pc", if1.instr_pc, 0);
        chk("rst_retired", if1.retired, 0);
        chk("rst_valid", if1.instr_valid, 0);
        chk("rst_next_ins", if1.next_ins, 0);
        chk("rst_rom_en", if1.rom_en, 0);
        chk("rst_busy", if1.busy, 0);
        chk("rst_halted", if1.halted, 0);
        tick();
        reset = 1'b0;
        tick();
        #1;
        chk("idle_busy", if1.busy, 0);

        // Basic fetch from address 5
        instr_ready = 1'b1;
        start_addr = 9'd5;
        start = 1'b1;
        tick();
        start = 1'b0;
        #1;
        chk("basic_rom_en", if1.rom_en, 1);
        chk("basic_rom_addr", if1.rom_addr, 5);
        chk("basic_busy", if1.busy, 1);
        chk("basic_valid_issue", if1.instr_valid, 0);
        tick();
        #1;
        chk("basic_rom_en_wait", if1.rom_en, 0);
        chk("basic_valid_wait", if1.instr_valid, 0);
        tick();
        #1;
        chk("basic_valid", if1.instr_valid, 1);
        chk("basic_instr", if1.instr, 9'h1A3);
        chk("basic_instr_pc", if1.instr_pc, 5);
        chk("basic_next_ins", if1.next_ins, 1);
        tick();
        instr_ready = 1'b0;
        #1;
        chk("basic_retired", if1.retired, 1);
        chk("basic_next_ins_off", if1.next_ins, 0);
        chk("basic_rom_addr_next", if1.rom_addr, 6);

        // Backpressure on address 6
        tick();
        tick();
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("bp_valid", if1.instr_valid, 1);
            chk("bp_instr", if1.instr, rom[6]);
            chk("bp_instr_pc", if1.instr_pc, 6);
            chk("bp_next_ins", if1.next_ins, 0);
            tick();
        end
        instr_ready = 1'b1;
        #1;
        chk("bp_release", if1.next_ins, 1);
        tick();
        #1;
        chk("bp_one_pulse", if1.next_ins, 0);
        chk("bp_rom_addr", if1.rom_addr, 7);
        chk("bp_retired", if1.retired, 2);

        // Halt: run 6..8 with doneAddress 8
        start_addr = 9'd6;
        done_addr = 9'd8;
        start = 1'b1;
        tick();
        start = 1'b0;
        pulses = 0;
        cyc = 0;
        while (cyc < 30) begin
            #1;
            if (if1.halted) break;
            if (if1.next_ins) pulses++;
            tick();
            cyc++;
        end
        chk("halt_in_time", cyc < 30, 1);
        chk("halt_halted", if1.halted, 1);
        chk("halt_retired", if1.retired, 2);
        chk("halt_pulses", pulses, 2);
        chk("halt_valid", if1.instr_valid, 0);
        chk("halt_busy", if1.busy, 0);
        chk("halt_next_ins", if1.next_ins, 0);
        held = if1.instr;
        tick();
        #1;
        chk("halt_stays", if1.halted, 1);
        chk("halt_next_ins_hold", if1.next_ins, 0);

        // Restart while in WAIT
        done_addr = 9'h1FF;
        start_addr = 9'd20;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        start_addr = 9'd30;
        start = 1'b1;
        #1;
        chk("rs_next_ins", if1.next_ins, 0);
        chk("rs_valid_wait", if1.instr_valid, 0);
        tick();
        start = 1'b0;
        #1;
        chk("rs_rom_addr", if1.rom_addr, 30);
        chk("rs_rom_en", if1.rom_en, 1);
        chk("rs_valid", if1.instr_valid, 0);
        chk("rs_retired", if1.retired, 0);
        chk("rs_instr_untouched", if1.instr, held);
        tick();
        tick();
        #1;
        chk("rs_instr", if1.instr, rom[30]);
        chk("rs_instr_pc", if1.instr_pc, 30);
        chk("rs_valid_now", if1.instr_valid, 1);
        tick();
        instr_ready = 1'b0;
        #1;
        chk("rs_retired_one", if1.retired, 1);

        // Asynchronous reset while in VALID
        tick();
        tick();
        #1;
        chk("ar_valid_before", if1.instr_valid, 1);
        chk("ar_instr_before", if1.instr, 9'h155);
        #1;
        reset = 1'b1;
        #1;
        chk("ar_instr", if1.instr, 0);
        chk("ar_instr_pc", if1.instr_pc, 0);
        chk("ar_retired", if1.retired, 0);
        chk("ar_valid", if1.instr_valid, 0);
        chk("ar_busy", if1.busy, 0);
        chk("ar_rom_en", if1.rom_en, 0);
        chk("ar_halted", if1.halted, 0);
        chk("ar_next_ins", if1.next_ins, 0);
        tick();
        reset = 1'b0;
        tick();

        // Randomized programs with random decode backpressure
        for (int run = 0; run < 8; run++) begin
            sa = int'($urandom_range(0, 400));
            n = int'($urandom_range(1, 5));
            start_addr = 9'(sa);
            done_addr = 9'(sa + n);
            exp_addr = 9'(sa);
            got = 0;
            start = 1'b1;
            tick();
            start = 1'b0;
            cyc = 0;
            while (cyc < 200) begin
                instr_ready = 1'($urandom_range(0, 1));
                #1;
                if (if1.halted) break;
                if (if1.instr_valid && instr_ready) begin
                    chk("rnd_instr", if1.instr, rom[exp_addr]);
                    chk("rnd_instr_pc", if1.instr_pc, exp_addr);
                    chk("rnd_next_ins", if1.next_ins, 1);
                    exp_addr = exp_addr + 9'd1;
                    got++;
                end else begin
                    chk("rnd_no_next_ins", if1.next_ins, 0);
                end
                tick();
                cyc++;
            end
            chk("rnd_in_time", cyc < 200, 1);
            chk("rnd_accepts", got, n);
            chk("rnd_retired", if1.retired, n);
            chk("rnd_halted", if1.halted, 1);
            tick();
        end

        // Saturation: 20 accepts, 4-bit counter holds at 15
        instr_ready = 1'b1;
        start_addr = 9'd100;
        done_addr = 9'h1FF;
        start = 1'b1;
        tick();
        start = 1'b0;
        pulses = 0;
        cyc = 0;
        while (cyc < 100) begin
            #1;
            if (if1.next_ins) pulses++;
            if (pulses == 20) break;
            tick();
            cyc++;
        end
        chk("sat_in_time", cyc < 100, 1);
        tick();
        #1;
        chk("sat_wide_retired", if1.retired, 20);
        chk("sat_narrow_retired", if2.retired, 15);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
